// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and fetch redirect.
// Ports: clk, rst (async active-low), fetch inputs ifPc/ifInst, decode
//   decisions branchTaken/jmp, ID/EX load info idExMemRead/idExRt;
//   outputs idPc/idInst/idValid, pcWrite, ifFlush, stall, and the perf
//   counters stallCount/flushCount (live only with HAZARD_PERF_CNT_EN).
module if_id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifPc,
    input  logic [31:0] ifInst,
    input  logic        branchTaken,
    input  logic        jmp,
    input  logic        idExMemRead,
    input  logic [4:0]  idExRt,
    output logic [31:0] idPc,
    output logic [31:0] idInst,
    output logic        idValid,
    output logic        pcWrite,
    output logic        ifFlush,
    output logic        stall,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       rsHit;
    logic       rtHit;
    logic       redirect;

    assign op = idInst[31:26];
    assign rs = idInst[25:21];
    assign rt = idInst[20:16];

    // Only R-type, beq and sw read rt as a source operand.
    always_comb begin
        usesRt = 1'b0;
        unique case (1'b1)
            (op == 6'b000000): usesRt = 1'b1;
            (op == 6'b000100): usesRt = 1'b1;
            (op == 6'b101011): usesRt = 1'b1;
            default:           usesRt = 1'b0;
        endcase
    end

    assign rsHit = (idExRt == rs);
    assign rtHit = usesRt & (idExRt == rt);

    // idValid gates the hazard so bubbles never stall.
    assign stall = idValid & idExMemRead & (idExRt != 5'd0)
                 & (rsHit | rtHit);

    // A stall suppresses the redirect; the branch is re-resolved next cycle.
    assign redirect = (branchTaken | jmp) & ~stall;
    assign ifFlush  = redirect;
    assign pcWrite  = ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idPc    <= 32'd0;
            idInst  <= 32'd0;
            idValid <= 1'b0;
        end else if (stall) begin
            idPc    <= idPc;
            idInst  <= idInst;
            idValid <= idValid;
        end else if (redirect) begin
            idPc    <= 32'd0;
            idInst  <= 32'd0;
            idValid <= 1'b0;
        end else begin
            idPc    <= ifPc;
            idInst  <= ifInst;
            idValid <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    // Saturating counters: stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            if (stall && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
            if (redirect && flushCnt != 16'hFFFF)
                flushCnt <= flushCnt + 16'd1;
        end
    end

    assign stallCount = stallCnt;
    assign flushCount = flushCnt;
`else
    assign stallCount = 16'd0;
    assign flushCount = 16'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard testbench for if_id_stage: directed vectors push expectations,
// a negedge monitor pops and compares every DUT output.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        branchTaken;
    logic        jmp;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic [31:0] idPc;
    logic [31:0] idInst;
    logic        idValid;
    logic        pcWrite;
    logic        ifFlush;
    logic        stall;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ifPc        (ifPc),
        .ifInst      (ifInst),
        .branchTaken (branchTaken),
        .jmp         (jmp),
        .idExMemRead (idExMemRead),
        .idExRt      (idExRt),
        .idPc        (idPc),
        .idInst      (idInst),
        .idValid     (idValid),
        .pcWrite     (pcWrite),
        .ifFlush     (ifFlush),
        .stall       (stall),
        .stallCount  (stallCount),
        .flushCount  (flushCount)
    );

    localparam logic [31:0] ADD  = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] ADDI = 32'h20250000; // addi $5,$1,0
    localparam logic [31:0] SW   = 32'hAC250000; // sw $5,0($1)
    localparam logic [31:0] BEQ  = 32'h10430000; // beq $2,$3,0
    localparam logic [31:0] JMP  = 32'h08000010; // j 0x40

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        pw;
        logic        fl;
        logic        st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] expSc    = 16'd0;
    logic [15:0] expFc    = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (idPc !== e.pc || idInst !== e.inst || idValid !== e.valid ||
                pcWrite !== e.pw || ifFlush !== e.fl || stall !== e.st ||
                stallCount !== e.sc || flushCount !== e.fc) begin
                failures++;
                $display("FAIL %s: got pc=%h inst=%h v=%b pw=%b fl=%b st=%b sc=%0d fc=%0d want pc=%h inst=%h v=%b pw=%b fl=%b st=%b sc=%0d fc=%0d",
                         e.name, idPc, idInst, idValid, pcWrite, ifFlush,
                         stall, stallCount, flushCount, e.pc, e.inst,
                         e.valid, e.pw, e.fl, e.st, e.sc, e.fc);
            end
        end
    end

    task automatic vec(
        input string       n,
        input logic        r,
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        br,
        input logic        j,
        input logic        mr,
        input logic [4:0]  xrt,
        input logic [31:0] ePc,
        input logic [31:0] eInst,
        input logic        eV,
        input logic        ePw,
        input logic        eFl,
        input logic        eSt
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ifPc        = pc;
        ifInst      = inst;
        branchTaken = br;
        jmp         = j;
        idExMemRead = mr;
        idExRt      = xrt;
        if (!r) begin
            expSc = 16'd0;
            expFc = 16'd0;
        end
        e.name  = n;
        e.pc    = ePc;
        e.inst  = eInst;
        e.valid = eV;
        e.pw    = ePw;
        e.fl    = eFl;
        e.st    = eSt;
`ifdef HAZARD_PERF_CNT_EN
        e.sc    = expSc;
        e.fc    = expFc;
`else
        e.sc    = 16'd0;
        e.fc    = 16'd0;
`endif
        sb.push_back(e);
        if (r) begin
            if (eSt && expSc != 16'hFFFF) expSc = expSc + 16'd1;
            if (eFl && expFc != 16'hFFFF) expFc = expFc + 16'd1;
        end
    endtask

    initial begin
        rst         = 1'b0;
        ifPc        = 32'd0;
        ifInst      = 32'd0;
        branchTaken = 1'b0;
        jmp         = 1'b0;
        idExMemRead = 1'b0;
        idExRt      = 5'd0;

        //  name          rst pc        inst         br j  mr rt    idPc      idInst       v  pw fl st
        vec("reset0",     0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 1, 5'd9, 32'h0, 32'h0, 0, 1, 0, 0);
        vec("reset1",     0, 32'h12345678, ADD,          0, 0, 1, 5'd1, 32'h0, 32'h0, 0, 1, 0, 0);
        vec("release",    1, 32'h4,  ADD,  0, 0, 0, 5'd0, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("ld_rs",      1, 32'h8,  ADDI, 0, 0, 1, 5'd9, 32'h4,  ADD,   1, 0, 0, 1);
        vec("ld_rs_hold", 1, 32'h8,  ADDI, 0, 0, 0, 5'd0, 32'h4,  ADD,   1, 1, 0, 0);
        vec("rt_filter",  1, 32'hC,  ADD,  0, 0, 1, 5'd5, 32'h8,  ADDI,  1, 1, 0, 0);
        vec("rt_zero",    1, 32'h10, SW,   0, 0, 1, 5'd0, 32'hC,  ADD,   1, 1, 0, 0);
        vec("sw_rt",      1, 32'h14, BEQ,  0, 0, 1, 5'd5, 32'h10, SW,    1, 0, 0, 1);
        vec("stall_br",   1, 32'h14, BEQ,  1, 0, 1, 5'd5, 32'h10, SW,    1, 0, 0, 1);
        vec("br_flush",   1, 32'h14, BEQ,  1, 0, 0, 5'd0, 32'h10, SW,    1, 1, 1, 0);
        vec("br_bubble",  1, 32'h18, JMP,  0, 0, 0, 5'd0, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("jmp_fetch",  1, 32'h1C, ADD,  0, 1, 0, 5'd0, 32'h18, JMP,   1, 1, 1, 0);
        vec("jmp_bubble", 1, 32'h20, ADD,  0, 1, 0, 5'd0, 32'h0,  32'h0, 0, 1, 1, 0);
        vec("jmp_after",  1, 32'h28, ADD,  0, 0, 1, 5'd9, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("refetch",    1, 32'h2C, ADDI, 0, 0, 0, 5'd0, 32'h28, ADD,   1, 1, 0, 0);
        vec("stall_pre",  1, 32'h30, ADDI, 0, 0, 1, 5'd8, 32'h2C, ADDI,  1, 1, 0, 0);
        vec("stall_on",   1, 32'h30, ADD,  0, 0, 1, 5'd1, 32'h30, ADDI,  1, 0, 0, 1);
        vec("rst_async",  0, 32'h30, ADD,  0, 0, 1, 5'd1, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("rst_rel",    1, 32'h4,  ADD,  0, 0, 0, 5'd0, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("cnt_s1",     1, 32'h8,  ADD,  0, 0, 1, 5'd10, 32'h4, ADD,   1, 0, 0, 1);
        vec("cnt_s2",     1, 32'h8,  ADD,  0, 0, 1, 5'd10, 32'h4, ADD,   1, 0, 0, 1);
        vec("cnt_s3",     1, 32'h8,  ADD,  0, 0, 1, 5'd10, 32'h4, ADD,   1, 0, 0, 1);
        vec("cnt_j1",     1, 32'h8,  ADD,  0, 1, 0, 5'd0, 32'h4,  ADD,   1, 1, 1, 0);
        vec("cnt_j2",     1, 32'h8,  ADD,  0, 1, 0, 5'd0, 32'h0,  32'h0, 0, 1, 1, 0);
        vec("cnt_end",    1, 32'hC,  ADD,  0, 0, 0, 5'd0, 32'h0,  32'h0, 0, 1, 0, 0);
        vec("cnt_fetch",  1, 32'hC,  ADD,  0, 0, 1, 5'd9, 32'hC,  ADD,   1, 0, 0, 1);

`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 65540; i++)
            vec("sat", 1, 32'h10, ADD, 0, 0, 1, 5'd9, 32'hC, ADD, 1, 0, 0, 1);
        vec("sat_end", 1, 32'h10, ADD, 0, 0, 0, 5'd0, 32'hC, ADD, 1, 1, 0, 0);
`endif

        for (int k = 0; k < 4 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
